// File: rtl/floor_request_scheduler_if.sv
// Handshake bundle between the elevator call scheduler and its environment.
// The master drives the buttons, the car position and the door status. The slave returns the scheduling outputs.
interface floor_request_scheduler_if #(
  parameter int NUM_FLOORS = 15,
  parameter int FLOOR_W    = 5
);
  logic [NUM_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]    cur_floor;
  logic                  door_open;
  logic [FLOOR_W-1:0]    requested_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;
  logic                  dir_down;
  logic                  busy;

  modport master (
    output call_req, cur_floor, door_open,
    input  requested_floor, pending, dir_up, dir_down, busy
  );

  modport slave (
    input  call_req, cur_floor, door_open,
    output requested_floor, pending, dir_up, dir_down, busy
  );
endinterface

// File: rtl/floor_request_scheduler.sv
// Elevator call scheduler. It latches call buttons and runs a LOOK-style direction FSM.
// It feeds the Controller's requested_floor, then clears served calls and holds at the floor for a dwell period.
module floor_request_scheduler #(
  parameter int NUM_FLOORS   = 15,
  parameter int FLOOR_W      = 5,
  parameter int DWELL_CYCLES = 4
) (
  input logic                     i_clk,
  input logic                     i_reset,
  floor_request_scheduler_if.slave bus
);
  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DWELL     = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [FLOOR_W-1:0]    r_target, w_target_nxt;
  logic [FLOOR_W-1:0]    r_req_floor, w_req_nxt;
  logic [DW_W-1:0]       r_dwell_cnt, w_dwell_nxt;
  logic                  r_last_dir, w_last_dir_nxt;
  logic [NUM_FLOORS-1:0] r_pending;
  logic                  r_dir_up, r_dir_down, r_busy;

  logic                  w_cur_valid;
  logic [NUM_FLOORS-1:0] w_cur_onehot, w_absorb, w_pend_all, w_clear;
  logic [FLOOR_W:0]      w_above, w_below;

  // Nearest set bit strictly above cur: {found, index}
  function automatic logic [FLOOR_W:0] find_above(input logic [NUM_FLOORS-1:0] vec,
                                                  input logic [FLOOR_W-1:0] cur);
    logic [FLOOR_W:0] res;
    res = {1'b0, {FLOOR_W{1'b0}}};
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (vec[i] && (FLOOR_W'(i) > cur)) res = {1'b1, FLOOR_W'(i)};
    end
    return res;
  endfunction

  // Nearest set bit strictly below cur: {found, index}
  function automatic logic [FLOOR_W:0] find_below(input logic [NUM_FLOORS-1:0] vec,
                                                  input logic [FLOOR_W-1:0] cur);
    logic [FLOOR_W:0] res;
    res = {1'b0, {FLOOR_W{1'b0}}};
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (vec[i] && (FLOOR_W'(i) < cur)) res = {1'b1, FLOOR_W'(i)};
    end
    return res;
  endfunction

  assign w_cur_valid = (bus.cur_floor < FLOOR_W'(NUM_FLOORS));

  // Current-floor one-hot. A call for the floor being dwelt at is absorbed, so the door simply re-opens.
  always_comb begin
    w_cur_onehot = {NUM_FLOORS{1'b0}};
    w_absorb     = {NUM_FLOORS{1'b0}};
    if (w_cur_valid) begin
      w_cur_onehot = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << bus.cur_floor;
    end else begin
      w_cur_onehot = {NUM_FLOORS{1'b0}};
    end
    if (r_state == S_DWELL) begin
      w_absorb = bus.call_req & w_cur_onehot;
    end else begin
      w_absorb = {NUM_FLOORS{1'b0}};
    end
  end

  assign w_pend_all = r_pending | (bus.call_req & ~w_absorb);
  assign w_above    = find_above(w_pend_all, bus.cur_floor);
  assign w_below    = find_below(w_pend_all, bus.cur_floor);

  // Next-state, target, dwell and clear logic. An invalid floor position freezes everything except call capture.
  always_comb begin
    w_state_nxt    = r_state;
    w_target_nxt   = r_target;
    w_dwell_nxt    = r_dwell_cnt;
    w_last_dir_nxt = r_last_dir;
    w_req_nxt      = r_req_floor;
    w_clear        = {NUM_FLOORS{1'b0}};
    if (w_cur_valid) begin
      case (r_state)
        S_IDLE: begin
          if (|(w_pend_all & w_cur_onehot)) begin
            w_clear     = w_cur_onehot;
            w_dwell_nxt = DWELL_LOAD;
            w_state_nxt = S_DWELL;
          end else if (w_above[FLOOR_W]) begin
            w_target_nxt   = w_above[FLOOR_W-1:0];
            w_last_dir_nxt = 1'b1;
            w_state_nxt    = S_MOVE_UP;
          end else if (w_below[FLOOR_W]) begin
            w_target_nxt   = w_below[FLOOR_W-1:0];
            w_last_dir_nxt = 1'b0;
            w_state_nxt    = S_MOVE_DOWN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_MOVE_UP: begin
          w_last_dir_nxt = 1'b1;
          if ((bus.cur_floor == r_target) && bus.door_open) begin
            w_clear     = w_cur_onehot;
            w_dwell_nxt = DWELL_LOAD;
            w_state_nxt = S_DWELL;
          end else if (w_above[FLOOR_W] && (w_above[FLOOR_W-1:0] < r_target)) begin
            w_target_nxt = w_above[FLOOR_W-1:0];
          end else begin
            w_target_nxt = r_target;
          end
        end
        S_MOVE_DOWN: begin
          w_last_dir_nxt = 1'b0;
          if ((bus.cur_floor == r_target) && bus.door_open) begin
            w_clear     = w_cur_onehot;
            w_dwell_nxt = DWELL_LOAD;
            w_state_nxt = S_DWELL;
          end else if (w_below[FLOOR_W] && (w_below[FLOOR_W-1:0] > r_target)) begin
            w_target_nxt = w_below[FLOOR_W-1:0];
          end else begin
            w_target_nxt = r_target;
          end
        end
        S_DWELL: begin
          if (|w_absorb) begin
            w_dwell_nxt = DWELL_LOAD;
          end else if (r_dwell_cnt != {DW_W{1'b0}}) begin
            w_dwell_nxt = r_dwell_cnt - DW_W'(1);
          end else if (r_last_dir ? w_above[FLOOR_W] : w_below[FLOOR_W]) begin
            w_target_nxt = r_last_dir ? w_above[FLOOR_W-1:0] : w_below[FLOOR_W-1:0];
            w_state_nxt  = r_last_dir ? S_MOVE_UP : S_MOVE_DOWN;
          end else if (r_last_dir ? w_below[FLOOR_W] : w_above[FLOOR_W]) begin
            w_target_nxt   = r_last_dir ? w_below[FLOOR_W-1:0] : w_above[FLOOR_W-1:0];
            w_state_nxt    = r_last_dir ? S_MOVE_DOWN : S_MOVE_UP;
            w_last_dir_nxt = ~r_last_dir;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
      if ((w_state_nxt == S_MOVE_UP) || (w_state_nxt == S_MOVE_DOWN)) begin
        w_req_nxt = w_target_nxt;
      end else begin
        w_req_nxt = bus.cur_floor;
      end
    end else begin
      w_req_nxt = r_req_floor;
    end
  end

  // State and registered outputs. Reset drops every outstanding call.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_target    <= {FLOOR_W{1'b0}};
      r_req_floor <= {FLOOR_W{1'b0}};
      r_dwell_cnt <= {DW_W{1'b0}};
      r_last_dir  <= 1'b1;
      r_pending   <= {NUM_FLOORS{1'b0}};
      r_dir_up    <= 1'b0;
      r_dir_down  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_target    <= w_target_nxt;
      r_req_floor <= w_req_nxt;
      r_dwell_cnt <= w_dwell_nxt;
      r_last_dir  <= w_last_dir_nxt;
      r_pending   <= w_pend_all & ~w_clear;
      r_dir_up    <= (w_state_nxt == S_MOVE_UP);
      r_dir_down  <= (w_state_nxt == S_MOVE_DOWN);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.requested_floor = r_req_floor;
  assign bus.pending         = r_pending;
  assign bus.dir_up          = r_dir_up;
  assign bus.dir_down        = r_dir_down;
  assign bus.busy            = r_busy;
endmodule
